dmem_port: RTL and testbench

//  Data-memory port of the memory stage. Takes one load/store from the core, runs the

---
 rtl/dmem_port_pkg.sv | 52 +++++
 rtl/dmem_port_if.sv | 25 ++
 rtl/dmem_port_align.sv | 28 ++
 rtl/dmem_port.sv | 109 ++++++++++
 tb/tb_dmem_port.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_port_pkg.sv
// Shared types for the data-memory port: request/response bundles, FSM states,
// and the store-lane and alignment helpers.
package dmem_port_pkg;

    typedef enum logic [1:0] {M_X = 2'd0, M_XRD = 2'd1, M_XWR = 2'd2} MemoryWriteSignal;

    typedef enum logic [2:0] {
        MT_X, MT_B, MT_H, MT_W, MT_D, MT_BU, MT_HU, MT_WU
    } MemoryMaskType;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        MemoryWriteSignal fcn;
        MemoryMaskType    typ;
    } MemoryRequest;

    typedef struct packed {
        MemoryRequest req;
        logic         req_valid;
    } MemoryIn;

    typedef struct packed {
        logic [31:0] data;
    } MemoryResponse;

    typedef struct packed {
        MemoryResponse res;
        logic          req_ready;
        logic          res_valid;
    } MemoryOut;

    typedef enum logic [1:0] {DM_IDLE, DM_REQ, DM_WAIT, DM_DONE} DmemState;

    function automatic logic [31:0] store_lanes(input logic [31:0] data, input MemoryMaskType typ);
        case (typ)
            MT_B, MT_BU: return {4{data[7:0]}};
            MT_H, MT_HU: return {2{data[15:0]}};
            default:     return data;
        endcase
    endfunction

    // Anything not byte or half is treated as a full word.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input MemoryMaskType typ);
        case (typ)
            MT_B, MT_BU: return 1'b0;
            MT_H, MT_HU: return addr_lo[0];
            default:     return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_port_if.sv
// Core-side and memory-side signals of the data-memory port, bundled for port lists.
interface dmem_port_if;
    import dmem_port_pkg::*;

    logic         core_req_valid;
    MemoryRequest core_req;
    logic         pipeline_kill;
    logic         core_stall;
    logic         core_resp_valid;
    logic [31:0]  core_rdata;
    logic         core_misaligned;
    MemoryIn      mem_in;
    MemoryOut     mem_out;

    modport slave (
        input  core_req_valid, core_req, pipeline_kill, mem_out,
        output core_stall, core_resp_valid, core_rdata, core_misaligned, mem_in
    );

    modport master (
        output core_req_valid, core_req, pipeline_kill, mem_out,
        input  core_stall, core_resp_valid, core_rdata, core_misaligned, mem_in
    );

endinterface

// File: rtl/dmem_port_align.sv
// Load-data extraction: picks the addressed byte/half from a memory word and
// sign- or zero-extends it according to the access type.
module dmem_align
    import dmem_port_pkg::*;
(
    input  logic [31:0]   word_i,
    input  logic [1:0]    addr_i,
    input  MemoryMaskType typ_i,
    output logic [31:0]   data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{addr_i, 3'b000} +: 8];
    assign half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        case (typ_i)
            MT_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            MT_BU:   data_o = {24'd0, byte_sel};
            MT_H:    data_o = {{16{half_sel[15]}}, half_sel};
            MT_HU:   data_o = {16'd0, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/dmem_port.sv
// Memory-stage data port: one outstanding load/store, MemoryIn/MemoryOut handshake,
// store lane replication, load extraction, and pipeline stall generation.
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter bit STORE_WAIT_ACK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_port_if.slave  bus
);

    DmemState     state_q, state_d;
    MemoryRequest req_q, req_d;
    logic         kill_q, kill_d;
    logic         mis_q, mis_d;
    logic [31:0]  rdata_q, rdata_d;
    logic [31:0]  load_data;
    logic [31:0]  resp_word;
    logic         accept;
    logic         is_store;
    MemoryIn      mem_in_o;

    dmem_align u_align (
        .word_i (bus.mem_out.res.data),
        .addr_i (req_q.addr[1:0]),
        .typ_i  (req_q.typ),
        .data_o (load_data)
    );

    assign accept    = (state_q == DM_IDLE) && bus.core_req_valid && (bus.core_req.fcn != M_X);
    assign is_store  = (req_q.fcn == M_XWR);
    assign resp_word = is_store ? 32'd0 : load_data;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        kill_d  = kill_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        case (state_q)
            DM_IDLE: begin
                if (accept) begin
                    req_d  = bus.core_req;
                    kill_d = 1'b0;
                    mis_d  = is_misaligned(bus.core_req.addr[1:0], bus.core_req.typ);
                    if (mis_d) begin
                        state_d = DM_DONE;
                        rdata_d = 32'd0;
                    end else begin
                        state_d = DM_REQ;
                    end
                end
            end
            DM_REQ: begin
                // Once the handshake happens the access must drain, so a kill only flags it.
                if (bus.mem_out.req_ready) begin
                    kill_d = bus.pipeline_kill;
                    if (bus.mem_out.res_valid || (is_store && !STORE_WAIT_ACK)) begin
                        state_d = DM_DONE;
                        rdata_d = resp_word;
                    end else begin
                        state_d = DM_WAIT;
                    end
                end else if (bus.pipeline_kill) begin
                    state_d = DM_IDLE;
                end
            end
            DM_WAIT: begin
                if (bus.pipeline_kill) kill_d = 1'b1;
                if (bus.mem_out.res_valid) begin
                    state_d = DM_DONE;
                    rdata_d = resp_word;
                end
            end
            DM_DONE: state_d = DM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DM_IDLE;
            req_q   <= '0;
            kill_q  <= 1'b0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            kill_q  <= kill_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        mem_in_o.req = req_q;
        if (is_store) mem_in_o.req.data = store_lanes(req_q.data, req_q.typ);
        mem_in_o.req_valid = (state_q == DM_REQ);
    end

    // Reset gates the combinational accept path so every output reads 0 while held.
    assign bus.core_stall      = !reset && (accept || state_q == DM_REQ || state_q == DM_WAIT);
    assign bus.core_resp_valid = (state_q == DM_DONE) && !kill_q;
    assign bus.core_misaligned = (state_q == DM_DONE) && !kill_q && mis_q;
    assign bus.core_rdata      = rdata_q;
    assign bus.mem_in          = mem_in_o;

endmodule

// File: tb/tb_dmem_port.sv
// Bench for dmem_port: table of directed accesses, hand-written multi-cycle
// sequences (stall, kill, reset, early store completion) and randomized accesses.
module tb_dmem_port;
    import dmem_port_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_port_if a ();
    dmem_port_if b ();

    dmem_port #(.STORE_WAIT_ACK(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(a));
    dmem_port #(.STORE_WAIT_ACK(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(b));

    int vec_n  = 0;
    int miss_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vec_n++;
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input MemoryMaskType t);
        case (t)
            MT_B, MT_BU: return 1;
            MT_H, MT_HU: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic logic m_mis(input logic [31:0] addr, input MemoryMaskType t);
        return (addr % size_of(t)) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                           input MemoryMaskType t);
        int s;
        int off;
        logic [63:0] mask;
        logic [63:0] v;
        s    = size_of(t);
        off  = (s == 4) ? 0 : int'(addr % 4);
        mask = (64'd1 << (8 * s)) - 64'd1;
        v    = ({32'd0, word} >> (8 * off)) & mask;
        if ((t == MT_B || t == MT_H) && v >= (64'd1 << (8 * s - 1))) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] data, input MemoryMaskType t);
        int s;
        logic [63:0] mask;
        logic [63:0] v;
        s    = size_of(t);
        mask = (64'd1 << (8 * s)) - 64'd1;
        v    = 64'd0;
        for (int i = 0; i < 4 / s; i++) v = v | (({32'd0, data} & mask) << (8 * s * i));
        return v[31:0];
    endfunction

    // One access on instance a with a memory that grants after rdly REQ cycles and
    // answers wdly cycles after the grant.
    task automatic access(input MemoryRequest r, input logic [31:0] mword, input int rdly,
                          input int wdly, output logic got, output logic [31:0] rdata,
                          output logic mis, output logic saw_req, output logic [31:0] maddr,
                          output logic [31:0] mdata, output int lat);
        int hs_wait;
        int res_wait;
        hs_wait = rdly;
        res_wait = -1;
        got = 0; rdata = 0; mis = 0; saw_req = 0; maddr = 0; mdata = 0; lat = -1;
        a.core_req = r;
        a.core_req_valid = 1'b1;
        for (int c = 0; c < 40 && !got; c++) begin
            a.mem_out = '0;
            if (a.mem_in.req_valid) begin
                saw_req = 1'b1;
                maddr = a.mem_in.req.addr;
                mdata = a.mem_in.req.data;
                if (hs_wait == 0) begin
                    a.mem_out.req_ready = 1'b1;
                    res_wait = wdly;
                end else hs_wait--;
            end else if (res_wait > 0) res_wait--;
            if (res_wait == 0) begin
                a.mem_out.res_valid = 1'b1;
                a.mem_out.res.data = mword;
                res_wait = -1;
            end
            @(negedge clk);
            if (a.core_resp_valid) begin
                got = 1'b1;
                rdata = a.core_rdata;
                mis = a.core_misaligned;
                lat = c;
            end
            tick();
        end
        a.core_req_valid = 1'b0;
        a.mem_out = '0;
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      data;
        MemoryWriteSignal fcn;
        MemoryMaskType    typ;
        logic [31:0]      mword;
        logic [31:0]      exp_rdata;
        logic             exp_mis;
        logic [31:0]      exp_mdata;
    } vec_t;

    vec_t tbl[13];
    MemoryMaskType ld_t[6] = '{MT_B, MT_H, MT_W, MT_BU, MT_HU, MT_X};
    MemoryMaskType st_t[3] = '{MT_B, MT_H, MT_W};

    initial begin
        MemoryRequest r;
        logic got, mis, saw;
        logic [31:0] rd, ma, md, exp_rd;
        logic exp_mis, st;
        int lat, rdl, wdl;

        tbl[0]  = '{32'h100, 32'h0,        M_XRD, MT_W,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{32'h103, 32'h0,        M_XRD, MT_B,  32'h80FFFF7F, 32'hFFFFFF80, 1'b0, 32'h0};
        tbl[2]  = '{32'h103, 32'h0,        M_XRD, MT_BU, 32'h80FFFF7F, 32'h00000080, 1'b0, 32'h0};
        tbl[3]  = '{32'h102, 32'h0,        M_XRD, MT_H,  32'h80FFFF7F, 32'hFFFF80FF, 1'b0, 32'h0};
        tbl[4]  = '{32'h102, 32'h0,        M_XRD, MT_HU, 32'h80FFFF7F, 32'h000080FF, 1'b0, 32'h0};
        tbl[5]  = '{32'h100, 32'h0,        M_XRD, MT_B,  32'h80FFFF7F, 32'h0000007F, 1'b0, 32'h0};
        tbl[6]  = '{32'h101, 32'h0,        M_XRD, MT_BU, 32'h80FFFF7F, 32'h000000FF, 1'b0, 32'h0};
        tbl[7]  = '{32'h108, 32'h0,        M_XRD, MT_X,  32'h01234567, 32'h01234567, 1'b0, 32'h0};
        tbl[8]  = '{32'h101, 32'h12,       M_XWR, MT_B,  32'h0,        32'h0,        1'b0, 32'h12121212};
        tbl[9]  = '{32'h102, 32'hABCD1234, M_XWR, MT_H,  32'h0,        32'h0,        1'b0, 32'h12341234};
        tbl[10] = '{32'h104, 32'hCAFEF00D, M_XWR, MT_W,  32'h0,        32'h0,        1'b0, 32'hCAFEF00D};
        tbl[11] = '{32'h102, 32'h0,        M_XRD, MT_W,  32'h0,        32'h0,        1'b1, 32'h0};
        tbl[12] = '{32'h101, 32'h5555,     M_XWR, MT_H,  32'h0,        32'h0,        1'b1, 32'h0};

        a.core_req_valid = 0; a.core_req = '0; a.pipeline_kill = 0; a.mem_out = '0;
        b.core_req_valid = 0; b.core_req = '0; b.pipeline_kill = 0; b.mem_out = '0;
        tick(); tick();
        chk1("rst_stall", a.core_stall, 1'b0);
        chk1("rst_resp", a.core_resp_valid, 1'b0);
        chk1("rst_mis", a.core_misaligned, 1'b0);
        chk("rst_rdata", a.core_rdata, 32'h0);
        chk1("rst_req_valid", a.mem_in.req_valid, 1'b0);
        reset = 1'b0;
        tick();

        // latency and stall window of a plain LW
        a.core_req = '{addr: 32'h100, data: 32'h0, fcn: M_XRD, typ: MT_W};
        a.core_req_valid = 1'b1;
        @(negedge clk);
        chk1("lat_stall_c0", a.core_stall, 1'b1);
        chk1("lat_reqv_c0", a.mem_in.req_valid, 1'b0);
        tick();
        a.mem_out = '{res: '{data: 32'hDEADBEEF}, req_ready: 1'b1, res_valid: 1'b1};
        @(negedge clk);
        chk1("lat_stall_c1", a.core_stall, 1'b1);
        chk1("lat_reqv_c1", a.mem_in.req_valid, 1'b1);
        chk1("lat_resp_c1", a.core_resp_valid, 1'b0);
        tick();
        a.mem_out = '0;
        @(negedge clk);
        chk1("lat_resp_c2", a.core_resp_valid, 1'b1);
        chk1("lat_stall_c2", a.core_stall, 1'b0);
        chk("lat_rdata_c2", a.core_rdata, 32'hDEADBEEF);
        tick();
        a.core_req_valid = 1'b0;
        @(negedge clk);
        chk1("lat_resp_c3", a.core_resp_valid, 1'b0);
        tick();

        // req_ready held low for 5 cycles
        a.core_req = '{addr: 32'h202, data: 32'h55AA0000, fcn: M_XRD, typ: MT_H};
        a.core_req_valid = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("hold_reqv", a.mem_in.req_valid, 1'b1);
            chk1("hold_stall", a.core_stall, 1'b1);
            chk("hold_addr", a.mem_in.req.addr, 32'h202);
            chk("hold_data", a.mem_in.req.data, 32'h55AA0000);
            tick();
        end
        a.mem_out = '{res: '{data: 32'h12348001}, req_ready: 1'b1, res_valid: 1'b1};
        tick();
        a.mem_out = '0;
        @(negedge clk);
        chk1("hold_resp", a.core_resp_valid, 1'b1);
        chk("hold_rdata", a.core_rdata, 32'h00001234);
        tick();
        a.core_req_valid = 1'b0;

        // kill at cycle 3 while still waiting for req_ready
        a.core_req = '{addr: 32'h300, data: 32'h0, fcn: M_XRD, typ: MT_W};
        a.core_req_valid = 1'b1;
        tick(); tick(); tick();
        a.pipeline_kill = 1'b1;
        @(negedge clk);
        chk1("kreq_reqv_c3", a.mem_in.req_valid, 1'b1);
        tick();
        a.pipeline_kill = 1'b0;
        a.core_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("kreq_reqv", a.mem_in.req_valid, 1'b0);
            chk1("kreq_resp", a.core_resp_valid, 1'b0);
            chk1("kreq_stall", a.core_stall, 1'b0);
            tick();
        end
        chk("kreq_rdata_held", a.core_rdata, 32'h00001234);

        // kill while waiting for the response
        a.core_req = '{addr: 32'h304, data: 32'h0, fcn: M_XRD, typ: MT_W};
        a.core_req_valid = 1'b1;
        tick();
        a.mem_out = '{res: '{data: 32'h0}, req_ready: 1'b1, res_valid: 1'b0};
        tick();
        a.mem_out = '0;
        a.pipeline_kill = 1'b1;
        @(negedge clk);
        chk1("kwait_stall", a.core_stall, 1'b1);
        chk1("kwait_reqv", a.mem_in.req_valid, 1'b0);
        tick();
        a.pipeline_kill = 1'b0;
        a.core_req_valid = 1'b0;
        a.mem_out = '{res: '{data: 32'h77777777}, req_ready: 1'b0, res_valid: 1'b1};
        @(negedge clk);
        chk1("kwait_resp_c3", a.core_resp_valid, 1'b0);
        tick();
        a.mem_out = '0;
        @(negedge clk);
        chk1("kwait_resp_c4", a.core_resp_valid, 1'b0);
        chk1("kwait_stall_c4", a.core_stall, 1'b0);
        tick();
        @(negedge clk);
        chk1("kwait_resp_c5", a.core_resp_valid, 1'b0);
        tick();

        // reset asserted mid-access in WAIT
        r = '{addr: 32'h400, data: 32'h0, fcn: M_XRD, typ: MT_W};
        access(r, 32'hA5A55A5A, 0, 0, got, rd, mis, saw, ma, md, lat);
        chk("pre_rst_rdata", rd, 32'hA5A55A5A);
        a.core_req = '{addr: 32'h404, data: 32'h0, fcn: M_XRD, typ: MT_W};
        a.core_req_valid = 1'b1;
        tick();
        a.mem_out = '{res: '{data: 32'h0}, req_ready: 1'b1, res_valid: 1'b0};
        tick();
        a.mem_out = '0;
        reset = 1'b1;
        a.core_req_valid = 1'b0;
        #1;
        chk1("rstw_reqv", a.mem_in.req_valid, 1'b0);
        chk1("rstw_stall", a.core_stall, 1'b0);
        chk1("rstw_resp", a.core_resp_valid, 1'b0);
        chk("rstw_rdata", a.core_rdata, 32'h0);
        tick();
        reset = 1'b0;
        a.mem_out = '{res: '{data: 32'h99999999}, req_ready: 1'b0, res_valid: 1'b1};
        @(negedge clk);
        chk1("rstw_late_resp", a.core_resp_valid, 1'b0);
        tick();
        a.mem_out = '0;
        @(negedge clk);
        chk1("rstw_late_resp2", a.core_resp_valid, 1'b0);
        chk("rstw_late_rdata", a.core_rdata, 32'h0);
        tick();

        // store completing at the request handshake
        b.core_req = '{addr: 32'h101, data: 32'h12, fcn: M_XWR, typ: MT_B};
        b.core_req_valid = 1'b1;
        tick();
        b.mem_out = '{res: '{data: 32'h0}, req_ready: 1'b1, res_valid: 1'b0};
        @(negedge clk);
        chk1("swa0_reqv", b.mem_in.req_valid, 1'b1);
        chk("swa0_data", b.mem_in.req.data, 32'h12121212);
        chk("swa0_addr", b.mem_in.req.addr, 32'h101);
        chk("swa0_typ", {29'd0, b.mem_in.req.typ}, {29'd0, MT_B});
        tick();
        b.mem_out = '0;
        @(negedge clk);
        chk1("swa0_resp", b.core_resp_valid, 1'b1);
        chk("swa0_rdata", b.core_rdata, 32'h0);
        tick();
        b.core_req_valid = 1'b0;

        // fcn M_X is not an access
        a.core_req = '{addr: 32'h500, data: 32'h0, fcn: M_X, typ: MT_W};
        a.core_req_valid = 1'b1;
        @(negedge clk);
        chk1("mx_stall", a.core_stall, 1'b0);
        tick();
        @(negedge clk);
        chk1("mx_reqv", a.mem_in.req_valid, 1'b0);
        a.core_req_valid = 1'b0;
        tick();

        // stray response while idle
        a.mem_out = '{res: '{data: 32'h31415926}, req_ready: 1'b0, res_valid: 1'b1};
        tick();
        a.mem_out = '0;
        @(negedge clk);
        chk1("stray_resp", a.core_resp_valid, 1'b0);
        tick();

        for (int i = 0; i < 13; i++) begin
            r = '{addr: tbl[i].addr, data: tbl[i].data, fcn: tbl[i].fcn, typ: tbl[i].typ};
            access(r, tbl[i].mword, 0, 0, got, rd, mis, saw, ma, md, lat);
            chk1($sformatf("tbl%0d_got", i), got, 1'b1);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk1($sformatf("tbl%0d_mis", i), mis, tbl[i].exp_mis);
            chk1($sformatf("tbl%0d_memreq", i), saw, !tbl[i].exp_mis);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), tbl[i].exp_mis ? 32'd1 : 32'd2);
            if (tbl[i].fcn == M_XWR && !tbl[i].exp_mis)
                chk($sformatf("tbl%0d_mdata", i), md, tbl[i].exp_mdata);
        end

        for (int i = 0; i < 150; i++) begin
            st = 1'($urandom_range(0, 1));
            r.addr = $urandom;
            if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
            r.data = $urandom;
            r.fcn = st ? M_XWR : M_XRD;
            r.typ = st ? st_t[$urandom_range(0, 2)] : ld_t[$urandom_range(0, 5)];
            rdl = int'($urandom_range(0, 3));
            wdl = int'($urandom_range(0, 3));
            ma = $urandom;
            exp_mis = m_mis(r.addr, r.typ);
            exp_rd = (st || exp_mis) ? 32'd0 : m_load(ma, r.addr, r.typ);
            access(r, ma, rdl, wdl, got, rd, mis, saw, ma, md, lat);
            chk1($sformatf("rnd%0d_got", i), got, 1'b1);
            chk($sformatf("rnd%0d_rdata", i), rd, exp_rd);
            chk1($sformatf("rnd%0d_mis", i), mis, exp_mis);
            chk1($sformatf("rnd%0d_memreq", i), saw, !exp_mis);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), exp_mis ? 32'd1 : 32'(2 + rdl + wdl));
            if (!exp_mis) chk($sformatf("rnd%0d_maddr", i), ma, r.addr);
            if (st && !exp_mis) chk($sformatf("rnd%0d_mdata", i), md, m_store(r.data, r.typ));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule
